// File: rtl/dma_responder.sv
// dma_responder: DMA command target. Latches a destination/length descriptor,
// moves words from a device port into data memory, then raises Interrupt
// and holds it until the CPU acknowledges.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | accepting commands, nextTransaction=1
//  S_FETCH | waiting for a device word (dev_ready=1)
//  S_WRITE | memory write pending; addr/data held until dma_mem_ready
//  S_IRQ   | transfer done, Interrupt=01 until ack
//  S_ERR   | illegal command, Interrupt=10 until ack, then descriptor cleared
module dma_responder #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memDataOut,
  output logic              nextTransaction,
  output logic [1:0]        Interrupt,
  input  logic              ack,
  input  logic              dev_valid,
  input  logic [31:0]       dev_data,
  output logic              dev_ready,
  output logic              dma_we,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [31:0]       dma_wdata,
  input  logic              dma_mem_ready
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_IRQ, S_ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_cmd;
  logic [1:0]        w_sel;
  logic              w_start;
  logic [LEN_W-1:0]  w_count_inc;
  logic [ADDR_W-1:0] w_dst_in;
  logic              w_unused;

  // Commands are only decoded while idle; anything else on en is dropped.
  assign w_cmd       = en && (r_state == S_IDLE);
  assign w_sel       = memAddr[3:2];
  assign w_start     = w_cmd && (w_sel == 2'b10) && memDataOut[0];
  assign w_count_inc = r_count + LEN_W'(1);
  assign w_dst_in    = ADDR_W'(memDataOut) & ~(ADDR_W'(3));
  assign w_unused    = &{1'b0, memAddr[31:4], memAddr[1:0]};

  assign dma_addr  = r_addr;
  assign dma_wdata = r_wdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next          = r_state;
    nextTransaction = 1'b0;
    Interrupt       = 2'b00;
    dev_ready       = 1'b0;
    dma_we          = 1'b0;
    case (r_state)
      S_IDLE: begin
        nextTransaction = 1'b1;
        if (w_cmd && (w_sel == 2'b11)) w_next = S_ERR;
        else if (w_start)              w_next = (r_len == '0) ? S_IRQ : S_FETCH;
      end
      S_FETCH: begin
        dev_ready = 1'b1;
        if (dev_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        dma_we = 1'b1;
        if (dma_mem_ready) w_next = (w_count_inc == r_len) ? S_IRQ : S_FETCH;
      end
      S_IRQ: begin
        Interrupt = 2'b01;
        if (ack) w_next = S_IDLE;
      end
      S_ERR: begin
        Interrupt = 2'b10;
        if (ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Descriptor, word counter and the held memory write beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_cmd && (w_sel == 2'b00)) r_dst <= w_dst_in;
      if (w_cmd && (w_sel == 2'b01)) r_len <= memDataOut[LEN_W-1:0];
      if (w_start)                   r_count <= '0;
      if ((r_state == S_FETCH) && dev_valid) begin
        r_wdata <= dev_data;
        r_addr  <= r_dst + (ADDR_W'(r_count) << 2);
      end
      if ((r_state == S_WRITE) && dma_mem_ready) r_count <= w_count_inc;
      if ((r_state == S_ERR) && ack) begin
        r_dst   <= '0;
        r_len   <= '0;
        r_count <= '0;
      end
    end
  end

endmodule
